hpi_responder: RTL and testbench

- Synthesizable responder for the four-register host port interface (HPI) that the SoC's PIOs drive: chip select, 2-bit address, read/write strobes and 16-bit data.
- Models the USB-controller side of the link: an address register, a word RAM with auto-increment, bidirectional mailboxes and a status register.
- Lets the HPI driver software and the interface glue be exercised on-chip and in simulation without the external chip.

---
 rtl/hpi_responder.sv | 191 +++++++++++++++++++
 tb/tb_hpi_responder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/hpi_responder.sv
// hpi_responder: device-side model of a four-register host port interface.
// Provides an address register, auto-incrementing word RAM, host/device
// mailboxes and a sticky status register behind a simple strobe protocol.
module hpi_responder #(
    parameter int MEM_AW = 12
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        hpi_cs_n,
    input  logic [1:0]  hpi_addr,
    input  logic        hpi_r_n,
    input  logic        hpi_w_n,
    input  logic [15:0] hpi_data_in,
    output logic [15:0] hpi_data_out,
    output logic        hpi_data_oe,
    output logic        hpi_int,
    output logic [15:0] dev_h2d_data,
    output logic        dev_h2d_valid,
    input  logic        dev_h2d_ack,
    input  logic [15:0] dev_d2h_data,
    input  logic        dev_d2h_wr,
    output logic        dev_d2h_full
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        REG_DATA    = 2'd0,
        REG_MAILBOX = 2'd1,
        REG_ADDRESS = 2'd2,
        REG_STATUS  = 2'd3
    } reg_sel_t;

    state_t      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] h2d_q, h2d_d;
    logic        h2d_full_q, h2d_full_d;
    logic [15:0] d2h_q, d2h_d;
    logic        d2h_full_q, d2h_full_d;
    logic        err_q, err_d;
    logic        ovr_q, ovr_d;
    logic [15:0] dout_q, dout_d;
    logic        oe_q, oe_d;

    logic [15:0] mem [0:(1 << MEM_AW) - 1];
    logic [MEM_AW-1:0] ram_idx;
    logic [15:0] ram_rdata;
    logic        ram_we;

    logic        selected;
    logic        rd_req;
    logic        wr_req;
    logic        both_req;
    logic        start;
    reg_sel_t    reg_sel;
    logic        unused_addr;

    assign selected = !hpi_cs_n;
    assign rd_req   = selected && !hpi_r_n && hpi_w_n;
    assign wr_req   = selected && hpi_r_n && !hpi_w_n;
    assign both_req = selected && !hpi_r_n && !hpi_w_n;
    assign start    = (state_q == ST_IDLE) && (rd_req || wr_req);
    assign reg_sel  = reg_sel_t'(hpi_addr);

    // Bit 0 selects a byte and is ignored; high bits alias onto the RAM.
    assign ram_idx     = addr_q[MEM_AW:1];
    assign ram_rdata   = mem[ram_idx];
    assign unused_addr = ^addr_q;

    // Next-state logic for the access FSM and all host/device visible registers.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        h2d_d      = h2d_q;
        h2d_full_d = h2d_full_q;
        d2h_d      = d2h_q;
        d2h_full_d = d2h_full_q;
        err_d      = err_q;
        ovr_d      = ovr_q;
        dout_d     = dout_q;
        ram_we     = 1'b0;

        // Device-side events first so that a same-cycle host action can override.
        if (dev_h2d_ack) begin
            h2d_full_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (both_req) begin
                    err_d = 1'b1;
                end else if (start) begin
                    state_d = ST_ACTIVE;
                    if (wr_req) begin
                        case (reg_sel)
                            REG_ADDRESS: addr_d = hpi_data_in;
                            REG_DATA: begin
                                ram_we = 1'b1;
                                addr_d = addr_q + 16'd2;
                            end
                            REG_MAILBOX: begin
                                h2d_d      = hpi_data_in;
                                h2d_full_d = 1'b1;
                                // A concurrent ack frees the slot, so no overrun.
                                if (h2d_full_q && !dev_h2d_ack) begin
                                    ovr_d = 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end else begin
                        case (reg_sel)
                            REG_DATA: begin
                                dout_d = ram_rdata;
                                addr_d = addr_q + 16'd2;
                            end
                            REG_ADDRESS: dout_d = addr_q;
                            REG_MAILBOX: begin
                                dout_d     = d2h_q;
                                d2h_full_d = 1'b0;
                            end
                            default: begin
                                dout_d = {err_q, 12'b0, ovr_q, h2d_full_q, d2h_full_q};
                                err_d  = 1'b0;
                                ovr_d  = 1'b0;
                            end
                        endcase
                    end
                end
            end
            default: begin
                if (hpi_cs_n || (hpi_r_n && hpi_w_n)) begin
                    state_d = ST_IDLE;
                end
            end
        endcase

        // A device write after a same-cycle mailbox read leaves the new word pending.
        if (dev_d2h_wr) begin
            d2h_d      = dev_d2h_data;
            d2h_full_d = 1'b1;
        end

        oe_d = (state_d == ST_ACTIVE) && ((start && rd_req) || oe_q);
    end

    // Register update with synchronous active-low reset.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            h2d_q      <= '0;
            h2d_full_q <= 1'b0;
            d2h_q      <= '0;
            d2h_full_q <= 1'b0;
            err_q      <= 1'b0;
            ovr_q      <= 1'b0;
            dout_q     <= '0;
            oe_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            h2d_q      <= h2d_d;
            h2d_full_q <= h2d_full_d;
            d2h_q      <= d2h_d;
            d2h_full_q <= d2h_full_d;
            err_q      <= err_d;
            ovr_q      <= ovr_d;
            dout_q     <= dout_d;
            oe_q       <= oe_d;
        end
    end

    // Word RAM write port; contents survive reset but no write happens during it.
    always_ff @(posedge clk_clk) begin
        if (ram_we && reset_reset_n) begin
            mem[ram_idx] <= hpi_data_in;
        end
    end

    assign hpi_data_out  = dout_q;
    assign hpi_data_oe   = oe_q;
    assign hpi_int       = d2h_full_q;
    assign dev_d2h_full  = d2h_full_q;
    assign dev_h2d_data  = h2d_q;
    assign dev_h2d_valid = h2d_full_q;

endmodule

// File: tb/tb_hpi_responder.sv
// Directed bench for hpi_responder: register access, RAM auto-increment and
// aliasing, mailboxes, simultaneous events and protocol error handling.
module tb_hpi_responder;

    localparam logic [1:0] A_DATA = 2'd0;
    localparam logic [1:0] A_MBOX = 2'd1;
    localparam logic [1:0] A_ADDR = 2'd2;
    localparam logic [1:0] A_STAT = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hpi_cs_n;
    logic [1:0]  hpi_addr;
    logic        hpi_r_n;
    logic        hpi_w_n;
    logic [15:0] hpi_data_in;
    logic [15:0] hpi_data_out;
    logic        hpi_data_oe;
    logic        hpi_int;
    logic [15:0] dev_h2d_data;
    logic        dev_h2d_valid;
    logic        dev_h2d_ack;
    logic [15:0] dev_d2h_data;
    logic        dev_d2h_wr;
    logic        dev_d2h_full;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hpi_responder #(.MEM_AW(12)) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .hpi_cs_n      (hpi_cs_n),
        .hpi_addr      (hpi_addr),
        .hpi_r_n       (hpi_r_n),
        .hpi_w_n       (hpi_w_n),
        .hpi_data_in   (hpi_data_in),
        .hpi_data_out  (hpi_data_out),
        .hpi_data_oe   (hpi_data_oe),
        .hpi_int       (hpi_int),
        .dev_h2d_data  (dev_h2d_data),
        .dev_h2d_valid (dev_h2d_valid),
        .dev_h2d_ack   (dev_h2d_ack),
        .dev_d2h_data  (dev_d2h_data),
        .dev_d2h_wr    (dev_d2h_wr),
        .dev_d2h_full  (dev_d2h_full)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [1:0] a, input logic [15:0] d);
        hpi_addr = a; hpi_data_in = d; hpi_cs_n = 1'b0; hpi_w_n = 1'b0;
        tick();
        hpi_cs_n = 1'b1; hpi_w_n = 1'b1;
        tick();
    endtask

    // Single read: oe and data one cycle after start, oe low after release.
    task automatic host_read(input string tag, input logic [1:0] a, input logic [15:0] exp);
        hpi_addr = a; hpi_cs_n = 1'b0; hpi_r_n = 1'b0;
        tick();
        chk({tag, "_oe"}, {15'b0, hpi_data_oe}, 16'd1);
        chk(tag, hpi_data_out, exp);
        hpi_cs_n = 1'b1; hpi_r_n = 1'b1;
        tick();
        chk({tag, "_oe_off"}, {15'b0, hpi_data_oe}, 16'd0);
        chk({tag, "_hold"}, hpi_data_out, exp);
    endtask

    task automatic dev_write(input logic [15:0] d);
        dev_d2h_data = d; dev_d2h_wr = 1'b1;
        tick();
        dev_d2h_wr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; hpi_cs_n = 1'b1; hpi_addr = 2'd0; hpi_r_n = 1'b1; hpi_w_n = 1'b1;
        hpi_data_in = '0; dev_h2d_ack = 1'b0; dev_d2h_data = '0; dev_d2h_wr = 1'b0;
        repeat (3) tick();
        chk("rst_dout", hpi_data_out, 16'h0000);
        chk("rst_oe", {15'b0, hpi_data_oe}, 16'd0);
        chk("rst_int", {15'b0, hpi_int}, 16'd0);
        chk("rst_h2d_valid", {15'b0, dev_h2d_valid}, 16'd0);
        chk("rst_d2h_full", {15'b0, dev_d2h_full}, 16'd0);
        rst_n = 1'b1;
        tick();

        host_read("stat0", A_STAT, 16'h0000);
        host_read("addr0", A_ADDR, 16'h0000);

        // Sequential RAM write/read with auto-increment.
        host_write(A_ADDR, 16'h1000);
        host_write(A_DATA, 16'hAAAA);
        host_write(A_DATA, 16'hBBBB);
        host_write(A_DATA, 16'hCCCC);
        host_read("addr_after_wr", A_ADDR, 16'h1006);
        host_write(A_ADDR, 16'h1000);
        host_read("data0", A_DATA, 16'hAAAA);
        host_read("data1", A_DATA, 16'hBBBB);
        host_read("data2", A_DATA, 16'hCCCC);
        host_read("addr_after_rd", A_ADDR, 16'h1006);

        // Top RAM word and aliasing through bits above MEM_AW.
        host_write(A_ADDR, 16'h1FFE);
        host_write(A_DATA, 16'h1234);
        host_read("addr_2000", A_ADDR, 16'h2000);
        host_write(A_ADDR, 16'h3FFE);
        host_read("alias_fff", A_DATA, 16'h1234);
        host_read("addr_4000", A_ADDR, 16'h4000);
        host_write(A_ADDR, 16'hFFFE);
        host_read("alias_fffe", A_DATA, 16'h1234);
        host_read("addr_wrap16", A_ADDR, 16'h0000);

        // Host-to-device mailbox, overrun and clear-on-read.
        host_write(A_MBOX, 16'h5A5A);
        chk("h2d_valid1", {15'b0, dev_h2d_valid}, 16'd1);
        chk("h2d_data1", dev_h2d_data, 16'h5A5A);
        host_write(A_MBOX, 16'h0001);
        chk("h2d_data2", dev_h2d_data, 16'h0001);
        host_read("stat_ovr", A_STAT, 16'h0006);
        host_read("stat_ovr_clr", A_STAT, 16'h0002);
        dev_h2d_ack = 1'b1;
        tick();
        dev_h2d_ack = 1'b0;
        chk("h2d_ack_clr", {15'b0, dev_h2d_valid}, 16'd0);
        host_read("stat_empty", A_STAT, 16'h0000);

        // Ack concurrent with a mailbox write start: new word pending, no overrun.
        host_write(A_MBOX, 16'h2222);
        hpi_addr = A_MBOX; hpi_data_in = 16'h3333; hpi_cs_n = 1'b0; hpi_w_n = 1'b0;
        dev_h2d_ack = 1'b1;
        tick();
        dev_h2d_ack = 1'b0; hpi_cs_n = 1'b1; hpi_w_n = 1'b1;
        tick();
        chk("h2d_ack_wr_data", dev_h2d_data, 16'h3333);
        chk("h2d_ack_wr_valid", {15'b0, dev_h2d_valid}, 16'd1);
        host_read("stat_no_ovr", A_STAT, 16'h0002);
        dev_h2d_ack = 1'b1;
        tick();
        dev_h2d_ack = 1'b0;

        // Device-to-host mailbox.
        dev_write(16'h00C3);
        chk("int_set", {15'b0, hpi_int}, 16'd1);
        chk("d2h_full_set", {15'b0, dev_d2h_full}, 16'd1);
        host_read("stat_d2h", A_STAT, 16'h0001);
        host_read("mbox_c3", A_MBOX, 16'h00C3);
        chk("int_clr", {15'b0, hpi_int}, 16'd0);

        // Device write in the read start cycle: old word returned, int stays set.
        dev_write(16'h0011);
        hpi_addr = A_MBOX; hpi_cs_n = 1'b0; hpi_r_n = 1'b0;
        dev_d2h_data = 16'h0022; dev_d2h_wr = 1'b1;
        tick();
        dev_d2h_wr = 1'b0;
        chk("mbox_race_data", hpi_data_out, 16'h0011);
        hpi_cs_n = 1'b1; hpi_r_n = 1'b1;
        tick();
        chk("mbox_race_int", {15'b0, hpi_int}, 16'd1);
        host_read("mbox_new", A_MBOX, 16'h0022);
        chk("int_clr2", {15'b0, hpi_int}, 16'd0);

        // Overwrite of a full d2h mailbox raises no flag.
        dev_write(16'h0033);
        dev_write(16'h0044);
        host_read("stat_d2h_ovw", A_STAT, 16'h0001);
        host_read("mbox_ovw", A_MBOX, 16'h0044);

        // Protocol error: both strobes low.
        host_write(A_ADDR, 16'h1000);
        hpi_addr = A_DATA; hpi_data_in = 16'hDEAD; hpi_cs_n = 1'b0; hpi_r_n = 1'b0; hpi_w_n = 1'b0;
        tick();
        chk("err_no_oe", {15'b0, hpi_data_oe}, 16'd0);
        hpi_cs_n = 1'b1; hpi_r_n = 1'b1; hpi_w_n = 1'b1;
        tick();
        host_read("err_addr_same", A_ADDR, 16'h1000);
        host_read("err_ram_same", A_DATA, 16'hAAAA);
        host_read("stat_err", A_STAT, 16'h8000);
        host_read("stat_err_clr", A_STAT, 16'h0000);

        // Held read performs one access only.
        host_write(A_ADDR, 16'h1002);
        hpi_addr = A_DATA; hpi_cs_n = 1'b0; hpi_r_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("held_oe", {15'b0, hpi_data_oe}, 16'd1);
            chk("held_data", hpi_data_out, 16'hBBBB);
        end
        hpi_cs_n = 1'b1; hpi_r_n = 1'b1;
        tick();
        chk("held_oe_off", {15'b0, hpi_data_oe}, 16'd0);
        chk("held_data_hold", hpi_data_out, 16'hBBBB);
        host_read("held_addr", A_ADDR, 16'h1004);

        // Reset mid-access clears state and abandons the access.
        hpi_addr = A_MBOX; hpi_data_in = 16'h7777; hpi_cs_n = 1'b0; hpi_w_n = 1'b0;
        rst_n = 1'b0;
        tick();
        chk("rst_mid_valid", {15'b0, dev_h2d_valid}, 16'd0);
        hpi_cs_n = 1'b1; hpi_w_n = 1'b1; rst_n = 1'b1;
        tick();
        chk("rst_mid_valid2", {15'b0, dev_h2d_valid}, 16'd0);
        host_read("rst_mid_addr", A_ADDR, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
